matrix_alu_seq: RTL and testbench

//  Parametrised, sequential successor of the combinational matrix ALU. Computes NxN matrix ops on signed

---
 rtl/matrix_alu_seq_pkg.sv | 47 ++++
 rtl/matrix_alu_seq_elem_unit.sv | 48 ++++
 rtl/matrix_alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_seq_pkg.sv
// Shared definitions for the sequential matrix ALU: op codes, FSM states,
// saturation and slot-offset helpers.
package matrix_alu_seq_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_OPP    = 3'b010;
  localparam logic [2:0] OP_MATMUL = 3'b011;
  localparam logic [2:0] OP_TRANS  = 3'b100;
  localparam logic [2:0] OP_SMUL   = 3'b110;

  // Working width for full-precision intermediates; covers ACC_W for DATA_W up to 13.
  localparam int SAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ELEM = 2'd1,
    ST_MAC  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                  input int data_w);
    logic signed [SAT_W-1:0] one_v;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    one_v = 32'sd1;
    max_v = (one_v <<< (data_w - 1)) - one_v;
    min_v = -(one_v <<< (data_w - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

  function automatic int slot(input int k, input int slot_w);
    return k * slot_w;
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/matrix_alu_seq_elem_unit.sv
// Combinational element datapath: computes one full-precision result element
// and clamps it to DATA_W, flagging any clamp.
module matrix_elem_unit
  import matrix_alu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic [2:0]               op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] scalar,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] elem,
  output logic                     ovf
);

  logic signed [SAT_W-1:0] a_s;
  logic signed [SAT_W-1:0] b_s;
  logic signed [SAT_W-1:0] scalar_s;
  logic signed [SAT_W-1:0] acc_s;
  logic signed [SAT_W-1:0] full_s;
  logic signed [SAT_W-1:0] sat_s;

  assign a_s      = SAT_W'(a);
  assign b_s      = SAT_W'(b);
  assign scalar_s = SAT_W'(scalar);
  assign acc_s    = SAT_W'(acc);

  // Full-precision element value followed by clamp to the DATA_W range
  always_comb begin
    full_s = {SAT_W{1'b0}};
    case (op)
      OP_ADD:    full_s = a_s + b_s;
      OP_SUB:    full_s = a_s - b_s;
      OP_OPP:    full_s = -a_s;
      OP_MATMUL: full_s = acc_s;
      OP_TRANS:  full_s = a_s;
      OP_SMUL:   full_s = a_s * scalar_s;
      default:   full_s = {SAT_W{1'b0}};
    endcase
    sat_s = sat(full_s, DATA_W);
  end

  assign elem = sat_s[DATA_W-1:0];
  assign ovf  = (sat_s != full_s);

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential NxN matrix ALU: one result element per clock for element-wise ops,
// one multiply-accumulate per clock for the row-by-column product.
module matrix_alu_seq
  import matrix_alu_seq_pkg::*;
#(
  parameter int N      = 5,
  parameter int DATA_W = 8,
  parameter int SLOT_W = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [N*N*SLOT_W-1:0]    matrix_a,
  input  logic [N*N*SLOT_W-1:0]    matrix_b,
  output logic [N*N*SLOT_W-1:0]    result,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int ACC_W = 2 * DATA_W + $clog2(N);
  localparam int IW    = $clog2(N);
  localparam int MW    = N * N * SLOT_W;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t                    state_r;
  state_t                    next_state_s;
  logic [2:0]                op_r;
  logic [MW-1:0]             a_r;
  logic [MW-1:0]             b_r;
  logic [MW-1:0]             result_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      ovf_r;
  logic [IW-1:0]             i_r;
  logic [IW-1:0]             j_r;
  logic [IW-1:0]             m_r;
  logic signed [ACC_W-1:0]   acc_r;

  logic                      accept_s;
  logic                      write_s;
  logic                      k_last_s;
  int                        a_idx_s;
  int                        b_idx_s;
  int                        k_idx_s;
  logic signed [DATA_W-1:0]  a_sel_s;
  logic signed [DATA_W-1:0]  b_sel_s;
  logic signed [DATA_W-1:0]  scalar_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]   acc_next_s;
  logic signed [DATA_W-1:0]  elem_s;
  logic signed [SLOT_W-1:0]  elem_slot_s;
  logic                      elem_ovf_s;

  assign k_last_s = (i_r == LAST_IDX) && (j_r == LAST_IDX);
  assign k_idx_s  = int'(i_r) * N + int'(j_r);
  assign scalar_s = b_r[DATA_W-1:0];

  // Operand addressing: MAC walks row i of A against column j of B, transpose reads A(j,i)
  always_comb begin
    a_idx_s = int'(i_r) * N + int'(j_r);
    b_idx_s = int'(i_r) * N + int'(j_r);
    if (state_r == ST_MAC) begin
      a_idx_s = int'(i_r) * N + int'(m_r);
      b_idx_s = int'(m_r) * N + int'(j_r);
    end else if (op_r == OP_TRANS) begin
      a_idx_s = int'(j_r) * N + int'(i_r);
      b_idx_s = int'(i_r) * N + int'(j_r);
    end else begin
      a_idx_s = int'(i_r) * N + int'(j_r);
      b_idx_s = int'(i_r) * N + int'(j_r);
    end
    a_sel_s = a_r[slot(a_idx_s, SLOT_W) +: DATA_W];
    b_sel_s = b_r[slot(b_idx_s, SLOT_W) +: DATA_W];
  end

  assign prod_s     = (2*DATA_W)'(a_sel_s) * (2*DATA_W)'(b_sel_s);
  assign acc_next_s = (m_r == IW'(0)) ? ACC_W'(prod_s) : (acc_r + ACC_W'(prod_s));
  assign elem_slot_s = SLOT_W'(elem_s);

  matrix_elem_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_elem (
    .op     (op_r),
    .a      (a_sel_s),
    .b      (b_sel_s),
    .scalar (scalar_s),
    .acc    (acc_next_s),
    .elem   (elem_s),
    .ovf    (elem_ovf_s)
  );

  // Next-state and per-cycle control decode
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    write_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (is_reserved(op)) begin
            next_state_s = ST_FIN;
          end else if (op == OP_MATMUL) begin
            next_state_s = ST_MAC;
          end else begin
            next_state_s = ST_ELEM;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ELEM: begin
        write_s      = 1'b1;
        next_state_s = k_last_s ? ST_FIN : ST_ELEM;
      end
      ST_MAC: begin
        if (m_r == LAST_IDX) begin
          write_s      = 1'b1;
          next_state_s = k_last_s ? ST_FIN : ST_MAC;
        end else begin
          write_s      = 1'b0;
          next_state_s = ST_MAC;
        end
      end
      ST_FIN:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      done_r  <= (state_r == ST_FIN);
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (state_r == ST_FIN) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Operand capture, element counters and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 3'b000;
      a_r   <= {MW{1'b0}};
      b_r   <= {MW{1'b0}};
      i_r   <= IW'(0);
      j_r   <= IW'(0);
      m_r   <= IW'(0);
      acc_r <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      op_r  <= op;
      a_r   <= matrix_a;
      b_r   <= matrix_b;
      i_r   <= IW'(0);
      j_r   <= IW'(0);
      m_r   <= IW'(0);
      acc_r <= {ACC_W{1'b0}};
    end else if (write_s) begin
      m_r   <= IW'(0);
      acc_r <= acc_next_s;
      if (k_last_s) begin
        i_r <= IW'(0);
        j_r <= IW'(0);
      end else if (j_r == LAST_IDX) begin
        i_r <= i_r + IW'(1);
        j_r <= IW'(0);
      end
      else begin
        j_r <= j_r + IW'(1);
      end
    end else if (state_r == ST_MAC) begin
      m_r   <= m_r + IW'(1);
      acc_r <= acc_next_s;
    end
  end

  // Result matrix and sticky overflow, cleared on every accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {MW{1'b0}};
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      result_r <= {MW{1'b0}};
      ovf_r    <= 1'b0;
    end else if (write_s) begin
      result_r[slot(k_idx_s, SLOT_W) +: SLOT_W] <= elem_slot_s;
      if (elem_ovf_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign result   = result_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed self-checking bench for matrix_alu_seq at N=5, DATA_W=8, SLOT_W=9.
module tb_matrix_alu_seq;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int SW = 9;
  localparam int MW = N * N * SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [MW-1:0] matrix_a;
  logic [MW-1:0] matrix_b;
  logic [MW-1:0] result;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  matrix_alu_seq #(.N(N), .DATA_W(DW), .SLOT_W(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs_v, input logic [255:0] exp_v);
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [MW-1:0] fill(input logic [SW-1:0] v);
    logic [MW-1:0] m;
    for (int k = 0; k < N * N; k++) m[k*SW +: SW] = v;
    return m;
  endfunction

  function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int i, input int j,
                                        input logic [SW-1:0] v);
    m[(i*N+j)*SW +: SW] = v;
    return m;
  endfunction

  function automatic logic [SW-1:0] get(input logic [MW-1:0] m, input int i, input int j);
    return m[(i*N+j)*SW +: SW];
  endfunction

  // Present a request for one cycle, then scramble operands to prove they were latched
  task automatic launch(input logic [2:0] o, input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    op = o; matrix_a = a; matrix_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; matrix_a = ~a; matrix_b = ~b;
  endtask

  task automatic wait_done(input string tag, inout int cycles);
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [MW-1:0] a,
                        input logic [MW-1:0] b, output int cycles);
    launch(o, a, b);
    check_eq({tag, "_busy"}, busy, 1'b1);
    cycles = 0;
    wait_done(tag, cycles);
  endtask

  task automatic check_pulse(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 1'b0);
  endtask

  logic [MW-1:0] a_v, b_v, e_v;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000;
    matrix_a = {MW{1'b0}}; matrix_b = {MW{1'b0}};
    #23;
    check_eq("rst_result", result, {MW{1'b0}});
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // add, padding bit set on A must be ignored
    run_op("add", 3'b000, fill(9'h103), fill(9'h004), lat);
    check_eq("add_lat", lat, 26);
    check_eq("add_res", result, fill(9'h007));
    check_eq("add_ovf", overflow, 1'b0);
    check_pulse("add");
    check_eq("add_hold", result, fill(9'h007));

    // sub saturating low: -100 - 100
    a_v = put({MW{1'b0}}, 0, 0, 9'h09C);
    b_v = put({MW{1'b0}}, 0, 0, 9'h064);
    run_op("sub", 3'b001, a_v, b_v, lat);
    check_eq("sub_res", result, put({MW{1'b0}}, 0, 0, 9'h180));
    check_eq("sub_ovf", overflow, 1'b1);

    // matmul identity x B
    a_v = {MW{1'b0}}; b_v = {MW{1'b0}};
    for (int i = 0; i < N; i++) begin
      a_v = put(a_v, i, i, 9'h001);
      for (int j = 0; j < N; j++) b_v = put(b_v, i, j, 9'(i * N + j));
    end
    run_op("mm_id", 3'b011, a_v, b_v, lat);
    check_eq("mm_id_lat", lat, 126);
    check_eq("mm_id_res", result, b_v);
    check_eq("mm_id_ovf", overflow, 1'b0);

    // matmul all 10: every element 500 -> 127
    run_op("mm_sat", 3'b011, fill(9'h00A), fill(9'h00A), lat);
    check_eq("mm_sat_res", result, fill(9'h07F));
    check_eq("mm_sat_ovf", overflow, 1'b1);

    // transpose of A(i,j)=i*5+j
    a_v = {MW{1'b0}}; e_v = {MW{1'b0}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_v = put(a_v, i, j, 9'(i * N + j));
        e_v = put(e_v, i, j, 9'(j * N + i));
      end
    run_op("trans", 3'b100, a_v, fill(9'h0FF), lat);
    check_eq("trans_lat", lat, 26);
    check_eq("trans_r10", get(result, 1, 0), 9'h001);
    check_eq("trans_r01", get(result, 0, 1), 9'h005);
    check_eq("trans_res", result, e_v);
    check_eq("trans_ovf", overflow, 1'b0);

    // opposite: -128 clamps to 127, others 2 -> -2
    a_v = put(fill(9'h002), 0, 0, 9'h080);
    run_op("opp", 3'b010, a_v, {MW{1'b0}}, lat);
    check_eq("opp_res", result, put(fill(9'h1FE), 0, 0, 9'h07F));
    check_eq("opp_ovf", overflow, 1'b1);

    // scalar mult by 5, scalar slot carries a padding bit
    b_v = put(fill(9'h0AA), 0, 0, 9'h105);
    run_op("smul", 3'b110, fill(9'h1FD), b_v, lat);
    check_eq("smul_res", result, fill(9'h1F1));
    check_eq("smul_ovf", overflow, 1'b0);

    // reserved ops finish in one clock with a cleared result
    run_op("rsv5", 3'b101, fill(9'h011), fill(9'h022), lat);
    check_eq("rsv5_lat", lat, 1);
    check_eq("rsv5_res", result, {MW{1'b0}});
    check_eq("rsv5_ovf", overflow, 1'b0);
    check_pulse("rsv5");
    run_op("rsv7", 3'b111, fill(9'h011), fill(9'h022), lat);
    check_eq("rsv7_lat", lat, 1);

    // start held high through busy with a different op must not restart
    launch(3'b000, fill(9'h003), fill(9'h004));
    start = 1'b1; op = 3'b001;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    wait_done("held", lat);
    check_eq("held_lat", lat, 26);
    check_eq("held_res", result, fill(9'h007));

    // async reset in the middle of a saturating matmul
    launch(3'b011, fill(9'h00A), fill(9'h00A));
    for (int c = 0; c < 51; c++) @(negedge clk);
    check_eq("mid_busy", busy, 1'b1);
    check_eq("mid_ovf", overflow, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_res", result, {MW{1'b0}});
    check_eq("arst_ovf", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;

    run_op("post", 3'b000, fill(9'h003), fill(9'h004), lat);
    check_eq("post_lat", lat, 26);
    check_eq("post_res", result, fill(9'h007));
    check_eq("post_ovf", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
